sap1_output_display: RTL and testbench
======================================

// Module: sap1_output_display
// PURPOSE
//  Downstream consumer of the SAP-1 output register (Data_out). Watches the 8-bit value, converts it
//  to BCD with a sequential double-dabble engine, and drives a 4-digit multiplexed common-anode
//  7-segment display with leading-zero blanking. Sits outside the CPU core, at the board edge.
// PARAMETERS
//  SCAN_DIV   1000  clk cycles each digit stays lit before the scan advances (>=2)
// PORTS
//  clk        in   1  system clock, rising-edge
//  nclr       in   1  asynchronous, active-low reset
//  data_in    in   8  value from the output register (Data_out)
//  busy       out  1  high while a conversion is in progress
//  conv_done  out  1  one-cycle pulse on the edge the new BCD value is committed
//  an_n       out  4  digit enables, active-low; bit0 = units, bit3 = sign/leftmost
//  seg_n      out  7  segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset (nclr=0, async): state IDLE; data_q=0; bcd_disp=0 (shows "0"); busy=0; conv_done=0;
//   prescaler=0; an_n=4'b1110; seg_n=7'b1000000. Reset mid-conversion aborts it and emits no conv_done.
//  FSM: IDLE, CONV.
//   IDLE: if data_in != data_q, then on that edge: data_q<=data_in; shift reg<=magnitude;
//    bcd_work<=0; cnt<=0; ->CONV. data_q updates only in IDLE, so changes during CONV are
//    picked up on the first IDLE cycle after the conversion ends. No explicit pending flag.
//   CONV: on each edge, add 3 to every BCD nibble >=5, then shift left one bit; cnt++.
//    On the 8th CONV edge (cnt==7): bcd_disp<=result (hundreds,tens,units); conv_done=1 for one
//    cycle; ->IDLE.
//  Latency: capture edge + 8 shift edges. bcd_disp changes 9 edges after data_in first differs.
//   busy=1 in CONV only (8 cycles).
//  Width: BCD work register is 12 bits (max 255 -> 2,5,5). Hundreds <=2.
//  Scan: prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit rotates
//   0->1->2->3->0. an_n is one-cold on the current digit. Digits are never all off and never
//   two on at once.
//  Blanking: hundreds is blank if 0. Tens is blank if hundreds==0 and tens==0. Units is always
//   shown. Blank = 7'b1111111.
//  Segment codes 0-9: 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,
//   0000000,0010000. Minus = 0111111.
//  Display reads only bcd_disp, which is held stable during conversion. No partial values shown.
// CONFIGURATION
//  SAP1_DISP_SIGNED_EN defined: data_in is two's complement. Magnitude = data_in[7] ? -data_in :
//   data_in, range 0..128. A sign flag is captured with data_q. Digit 3 shows minus when the
//   flag is set, otherwise blank.
//  Undefined: data_in is unsigned 0..255. Digit 3 is still scanned but is always blank.
// STRUCTURE
//  Shared header sap1_defs.vh: segment-code localparams (SEG_0..SEG_9, SEG_BLANK, SEG_MINUS)
//   and FSM state encodings. The CPU top and benches reuse it.
//  Sub-module sap1_seg7_decode: combinational, 4-bit digit + blank + minus -> seg_n.
//   Instantiated once, after the digit mux.
//  Top: capture/FSM, double-dabble datapath, prescaler + digit ring, blanking logic.
// TESTING (bench uses SCAN_DIV=4)
//  1 Reset: hold nclr=0 -> an_n=4'b1110, seg_n=7'b1000000, busy=0, conv_done=0. Check
//    asynchronously, before any clk edge.
//  2 Unsigned: data_in 0->123 -> busy high 8 cycles; conv_done pulse 9 edges after the change.
//    Scan shows d0=0110000, d1=0100100, d2=1111001, d3=1111111.
//  3 Blanking: data_in=7 -> d0=1111000, d1=d2=d3=1111111. data_in=105 -> d1 shows 0 (1000000),
//    not blank.
//  4 Change mid-conversion: 10 then 20 three cycles later -> first conv_done shows 10. The second
//    conversion starts on the next cycle. Second conv_done shows 20. Exactly two pulses.
//  5 Signed build: 8'hFF -> d3=0111111, d0=1111001, d1=d2 blank. 8'h80 -> d3=minus, then 1,2,8.
//    8'h7F -> d3 blank, then 1,2,7.
//  6 Reset mid-conversion: nclr=0 at CONV cycle 4 -> immediate reset values. No conv_done.
//    After release, the first conversion restarts from data_q=0.

Source files
------------

// File: rtl/sap1_output_display_pkg.sv
// Shared definitions for the SAP-1 output display: segment codes, FSM states, BCD helpers.
package sap1_output_display_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Common-anode, active-low, ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = SEG_0;
            4'd1:    seg_code = SEG_1;
            4'd2:    seg_code = SEG_2;
            4'd3:    seg_code = SEG_3;
            4'd4:    seg_code = SEG_4;
            4'd5:    seg_code = SEG_5;
            4'd6:    seg_code = SEG_6;
            4'd7:    seg_code = SEG_7;
            4'd8:    seg_code = SEG_8;
            4'd9:    seg_code = SEG_9;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: any nibble >=5 gets +3 so the following shift carries decimally
    function automatic logic [11:0] dd_adjust(input logic [11:0] b);
        logic [3:0] n;
        dd_adjust = b;
        for (int i = 0; i < 3; i++) begin
            n = b[i*4 +: 4];
            if (n >= 4'd5) n = n + 4'd3;
            dd_adjust[i*4 +: 4] = n;
        end
    endfunction

endpackage

// File: rtl/sap1_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern, with blank and minus overrides.
module sap1_seg7_decode
    import sap1_output_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = seg_code(digit);
        if (blank) seg_n = SEG_BLANK;
        if (minus) seg_n = SEG_MINUS;
    end

endmodule

// File: rtl/sap1_output_display.sv
// SAP-1 output register display: sequential binary-to-BCD conversion and 4-digit scanned display.
// Define SAP1_DISP_SIGNED_EN to treat data_in as two's complement with a minus sign on digit 3.
module sap1_output_display
    import sap1_output_display_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       nclr,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       conv_done,
    output logic [3:0] an_n,
    output logic [6:0] seg_n
);

    localparam int PW = $clog2(SCAN_DIV);

    state_t        state, state_nx;
    logic [7:0]    data_q, sh_q, mag;
    logic [11:0]   bcd_work, bcd_disp, bcd_adj;
    logic [19:0]   dd_next;
    logic [2:0]    cnt;
    logic          load, commit;
    logic [PW-1:0] presc;
    logic [1:0]    dig;
    logic [3:0]    digit_v;
    logic          blank, minus;

`ifdef SAP1_DISP_SIGNED_EN
    logic sign_work, sign_disp;
    assign mag = data_in[7] ? -data_in : data_in;
`else
    assign mag = data_in;
`endif

    assign load    = (state == IDLE) && (data_in != data_q);
    assign commit  = (state == CONV) && (cnt == 3'd7);
    assign busy    = (state == CONV);
    assign bcd_adj = dd_adjust(bcd_work);
    assign dd_next = {bcd_adj, sh_q} << 1;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load)   state_nx = CONV;
            CONV:    if (commit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            data_q    <= '0;
            sh_q      <= '0;
            bcd_work  <= '0;
            bcd_disp  <= '0;
            cnt       <= '0;
            conv_done <= 1'b0;
`ifdef SAP1_DISP_SIGNED_EN
            sign_work <= 1'b0;
            sign_disp <= 1'b0;
`endif
        end else begin
            conv_done <= commit;
            if (load) begin
                data_q   <= data_in;
                sh_q     <= mag;
                bcd_work <= '0;
                cnt      <= '0;
`ifdef SAP1_DISP_SIGNED_EN
                sign_work <= data_in[7];
`endif
            end else if (state == CONV) begin
                bcd_work <= dd_next[19:8];
                sh_q     <= dd_next[7:0];
                cnt      <= cnt + 3'd1;
                // Sign and digits move to the display together so no mixed value is ever shown
                if (commit) begin
                    bcd_disp <= dd_next[19:8];
`ifdef SAP1_DISP_SIGNED_EN
                    sign_disp <= sign_work;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            presc <= '0;
            dig   <= '0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            dig   <= dig + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign an_n = ~(4'b0001 << dig);

    always_comb begin
        digit_v = bcd_disp[3:0];
        blank   = 1'b0;
        minus   = 1'b0;
        case (dig)
            2'd1: begin
                digit_v = bcd_disp[7:4];
                blank   = (bcd_disp[11:4] == 8'd0);
            end
            2'd2: begin
                digit_v = bcd_disp[11:8];
                blank   = (bcd_disp[11:8] == 4'd0);
            end
            2'd3: begin
                digit_v = 4'd0;
                blank   = 1'b1;
`ifdef SAP1_DISP_SIGNED_EN
                minus   = sign_disp;
`endif
            end
            default: ;
        endcase
    end

    sap1_seg7_decode u_dec (
        .digit (digit_v),
        .blank (blank),
        .minus (minus),
        .seg_n (seg_n)
    );

endmodule

// File: tb/tb_sap1_output_display.sv
// Directed bench for sap1_output_display with a conv_done scoreboard and scanned-display checks.
module tb_sap1_output_display;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       nclr;
    logic [7:0] data_in;
    logic       busy, conv_done;
    logic [3:0] an_n;
    logic [6:0] seg_n;

    int n_assert = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    logic [7:0] exp_q[$];

    sap1_output_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .nclr      (nclr),
        .data_in   (data_in),
        .busy      (busy),
        .conv_done (conv_done),
        .an_n      (an_n),
        .seg_n     (seg_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] tab(input int d);
        case (d)
            0: tab = 7'b1000000;  1: tab = 7'b1111001;  2: tab = 7'b0100100;
            3: tab = 7'b0110000;  4: tab = 7'b0011001;  5: tab = 7'b0010010;
            6: tab = 7'b0000010;  7: tab = 7'b1111000;  8: tab = 7'b0000000;
            9: tab = 7'b0010000;  default: tab = 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [7:0] v, input int d);
        int m, h, t, u;
        logic neg;
        neg = 1'b0;
        m = int'(v);
`ifdef SAP1_DISP_SIGNED_EN
        if (v[7]) begin
            neg = 1'b1;
            m = 256 - int'(v);
        end
`endif
        h = m / 100;
        t = (m / 10) % 10;
        u = m % 10;
        case (d)
            0:       exp_seg = tab(u);
            1:       exp_seg = (h == 0 && t == 0) ? 7'b1111111 : tab(t);
            2:       exp_seg = (h == 0) ? 7'b1111111 : tab(h);
            default: exp_seg = neg ? 7'b0111111 : 7'b1111111;
        endcase
    endfunction

    // Scoreboard: each conv_done must match a queued value, and the lit digit must already show it
    always @(negedge clk) begin
        if (nclr && conv_done) begin
            logic [7:0] v;
            int d;
            pulse_cnt++;
            chk("sb_nonempty", exp_q.size() > 0, 1);
            v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            d = 0;
            for (int i = 0; i < 4; i++) if (!an_n[i]) d = i;
            chk("sb_onecold", $countones(~an_n), 1);
            chk("sb_seg", seg_n, exp_seg(v, d));
        end
    end

    task automatic time_conv(input string tag);
        int busy_n, done_at, p0;
        busy_n = 0; done_at = 0; p0 = pulse_cnt;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (busy) busy_n++;
            if (conv_done && done_at == 0) done_at = k;
        end
        chk({tag, "_latency"}, done_at, 9);
        chk({tag, "_busy"}, busy_n, 8);
        chk({tag, "_pulses"}, pulse_cnt - p0, 1);
    endtask

    task automatic run_conv(input logic [7:0] v, input string tag);
        @(negedge clk);
        data_in = v;
        exp_q.push_back(v);
        time_conv(tag);
    endtask

    task automatic check_display(input logic [7:0] v, input string tag);
        logic [3:0] tgt;
        for (int d = 0; d < 4; d++) begin
            tgt = ~(4'b0001 << d);
            for (int w = 0; w < 4 * SCAN_DIV + 2 && an_n !== tgt; w++) @(negedge clk);
            chk({tag, "_an"}, an_n, tgt);
            chk({tag, "_seg"}, seg_n, exp_seg(v, d));
        end
    endtask

    initial begin
        int p0, d1, d2, w;
        logic [3:0] prev;

        // Reset values, before any clock edge
        nclr = 1'b0;
        data_in = 8'd0;
        #1;
        chk("rst_an", an_n, 4'b1110);
        chk("rst_seg", seg_n, 7'b1000000);
        chk("rst_busy", busy, 0);
        chk("rst_done", conv_done, 0);
        @(negedge clk);
        @(negedge clk);
        nclr = 1'b1;

        run_conv(8'd123, "u123");
        check_display(8'd123, "d123");

        // Scan period: each digit stays lit SCAN_DIV cycles
        @(negedge clk);
        prev = an_n;
        for (w = 0; w < 20 && an_n === prev; w++) @(negedge clk);
        prev = an_n;
        for (w = 0; w < 20 && an_n === prev; w++) @(negedge clk);
        chk("scan_period", w, SCAN_DIV);

        run_conv(8'd7, "u7");
        check_display(8'd7, "d7");
        run_conv(8'd105, "u105");
        check_display(8'd105, "d105");
        run_conv(8'd255, "u255");
        check_display(8'd255, "d255");

        // Rewriting the same value must not start a conversion
        p0 = pulse_cnt;
        @(negedge clk);
        data_in = 8'd255;
        w = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (busy) w++;
        end
        chk("same_busy", w, 0);
        chk("same_pulses", pulse_cnt - p0, 0);

        // Change during conversion: picked up on the first idle cycle after completion
        p0 = pulse_cnt;
        d1 = 0; d2 = 0;
        @(negedge clk);
        data_in = 8'd10;
        exp_q.push_back(8'd10);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin
                @(negedge clk);
                data_in = 8'd20;
                exp_q.push_back(8'd20);
            end
            if (conv_done) begin
                if (d1 == 0) d1 = k;
                else if (d2 == 0) d2 = k;
            end
        end
        chk("mid_first", d1, 9);
        chk("mid_second", d2, 18);
        chk("mid_pulses", pulse_cnt - p0, 2);
        check_display(8'd20, "d20");

`ifdef SAP1_DISP_SIGNED_EN
        run_conv(8'hFF, "sFF");
        check_display(8'hFF, "dFF");
        run_conv(8'h80, "s80");
        check_display(8'h80, "d80");
        run_conv(8'h7F, "s7F");
        check_display(8'h7F, "d7F");
`endif

        // Reset during conversion cycle 4 aborts without a pulse; restart from data_q=0
        p0 = pulse_cnt;
        @(negedge clk);
        data_in = 8'd50;
        exp_q.push_back(8'd50);
        repeat (4) @(posedge clk);
        @(negedge clk);
        nclr = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", conv_done, 0);
        chk("mrst_an", an_n, 4'b1110);
        chk("mrst_seg", seg_n, 7'b1000000);
        repeat (3) @(negedge clk);
        chk("mrst_pulses", pulse_cnt - p0, 0);
        nclr = 1'b1;
        time_conv("restart");
        check_display(8'd50, "d50");
        chk("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
